// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the instruction step sequencer:
//   - step encodings presented on the step output
//   - the state enumeration built on those encodings
//   - default opcode constants for the supported instructions
//   - the decoded opcode class used by the sequencer
// -----------------------------------------------------------------------------
package seq_pkg;

   // Step encodings, visible to software/debug through the step port
   localparam logic [3:0] STEP_IDLE   = 4'd0;
   localparam logic [3:0] STEP_T0     = 4'd1;
   localparam logic [3:0] STEP_T1     = 4'd2;
   localparam logic [3:0] STEP_T2     = 4'd3;
   localparam logic [3:0] STEP_T3     = 4'd4;
   localparam logic [3:0] STEP_T4     = 4'd5;
   localparam logic [3:0] STEP_T5     = 4'd6;
   localparam logic [3:0] STEP_T6     = 4'd7;
   localparam logic [3:0] STEP_HALTED = 4'd8;

   typedef enum logic [3:0] {
      ST_IDLE   = STEP_IDLE,
      ST_T0     = STEP_T0,
      ST_T1     = STEP_T1,
      ST_T2     = STEP_T2,
      ST_T3     = STEP_T3,
      ST_T4     = STEP_T4,
      ST_T5     = STEP_T5,
      ST_T6     = STEP_T6,
      ST_HALTED = STEP_HALTED
   } state_t;

   // Default opcodes
   localparam logic [4:0] DEF_OP_JR   = 5'b10100;
   localparam logic [4:0] DEF_OP_JAL  = 5'b10011;
   localparam logic [4:0] DEF_OP_BR   = 5'b10010;
   localparam logic [4:0] DEF_OP_HALT = 5'b11011;

   // Opcode class after decode; anything unrecognised is OPC_ILLEGAL
   typedef enum logic [2:0] {
      OPC_JR      = 3'd0,
      OPC_JAL     = 3'd1,
      OPC_BR      = 3'd2,
      OPC_HALT    = 3'd3,
      OPC_ILLEGAL = 3'd4
   } op_class_t;

endpackage

// File: rtl/mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts memory-wait cycles spent in the fetch read step and flags a timeout.
// The count is held at zero outside the wait step, so it is clear on every
// entry to that step, and it saturates at WAIT_MAX instead of wrapping.
// expired is high in the wait cycle that would bring the count to WAIT_MAX,
// so the sequencer leaves the wait step after exactly WAIT_MAX wait cycles.
//
// Ports:
//   clock     in   system clock, rising edge
//   clear     in   asynchronous active-high reset
//   in_wait   in   sequencer is in the memory read step
//   mem_ready in   memory read data valid
//   expired   out  this wait cycle reaches the WAIT_MAX limit
// -----------------------------------------------------------------------------
module mem_wait_timer #(
   parameter int WAIT_MAX = 16
)(
   input  logic clock,
   input  logic clear,
   input  logic in_wait,
   input  logic mem_ready,
   output logic expired
);

   localparam int CW = $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_MAX   = CW'(WAIT_MAX);
   localparam logic [CW-1:0] LAST_WAIT = CW'(WAIT_MAX - 1);

   logic [CW-1:0] count_r;

   // Wait-cycle counter: zero outside the wait step, saturating inside it
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         count_r <= CNT_ZERO;
      end else if (!in_wait) begin
         count_r <= CNT_ZERO;
      end else if (!mem_ready && (count_r != CNT_MAX)) begin
         count_r <= count_r + CNT_ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = in_wait && !mem_ready && (count_r >= LAST_WAIT);

endmodule

// File: rtl/step_sequencer.sv
// -----------------------------------------------------------------------------
// step_sequencer
// Hardwired control-step sequencer: fetch (T0..T2) followed by an opcode
// dependent execute sequence (JR, JAL, BR, HALT). State is registered; the
// datapath strobes are decoded combinationally from the current state, the
// opcode, con_ff and mem_ready. A memory wait that runs for WAIT_MAX cycles
// halts the sequencer and sets the sticky fault flag.
//
// Ports:
//   clock       in   system clock, rising edge
//   clear       in   asynchronous active-high reset
//   run         in   start from IDLE / resume from HALTED
//   opcode      in   IR opcode field (valid from T3)
//   con_ff      in   branch condition flip-flop
//   mem_ready   in   memory read data valid
//   PCout..link_sel out  datapath control strobes
//   step        out  current state encoding (see seq_pkg)
//   busy        out  in T0..T6
//   halted      out  in HALTED
//   fault       out  sticky memory-timeout flag
//   illegal_op  out  unknown opcode seen in T3 (one cycle)
// -----------------------------------------------------------------------------
module step_sequencer
   import seq_pkg::*;
#(
   parameter int             OPW      = 5,
   parameter logic [OPW-1:0] OP_JR    = OPW'(DEF_OP_JR),
   parameter logic [OPW-1:0] OP_JAL   = OPW'(DEF_OP_JAL),
   parameter logic [OPW-1:0] OP_BR    = OPW'(DEF_OP_BR),
   parameter logic [OPW-1:0] OP_HALT  = OPW'(DEF_OP_HALT),
   parameter int             WAIT_MAX = 16
)(
   input  logic           clock,
   input  logic           clear,
   input  logic           run,
   input  logic [OPW-1:0] opcode,
   input  logic           con_ff,
   input  logic           mem_ready,
   output logic           PCout,
   output logic           MARin,
   output logic           IncPC,
   output logic           ZLowIn,
   output logic           ZLowOut,
   output logic           PCin,
   output logic           Read,
   output logic           MDRin,
   output logic           MDRout,
   output logic           IRin,
   output logic           Gra,
   output logic           Grb,
   output logic           Grc,
   output logic           Rout,
   output logic           Rin,
   output logic           CONin,
   output logic           Yin,
   output logic           Cout,
   output logic           alu_add,
   output logic           link_sel,
   output logic [3:0]     step,
   output logic           busy,
   output logic           halted,
   output logic           fault,
   output logic           illegal_op
);

   state_t    state_r;
   logic      fault_r;
   op_class_t op_class_s;
   logic      in_wait_s;
   logic      timeout_s;

   assign in_wait_s = (state_r == ST_T1);

   mem_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_wait (
      .clock     (clock),
      .clear     (clear),
      .in_wait   (in_wait_s),
      .mem_ready (mem_ready),
      .expired   (timeout_s)
   );

   // Opcode decode into an instruction class
   always_comb begin
      op_class_s = OPC_ILLEGAL;
      if (opcode == OP_JR) begin
         op_class_s = OPC_JR;
      end else if (opcode == OP_JAL) begin
         op_class_s = OPC_JAL;
      end else if (opcode == OP_BR) begin
         op_class_s = OPC_BR;
      end else if (opcode == OP_HALT) begin
         op_class_s = OPC_HALT;
      end else begin
         op_class_s = OPC_ILLEGAL;
      end
   end

   // State register, next-state selection and sticky timeout flag
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_r <= ST_IDLE;
         fault_r <= 1'b0;
      end else begin
         fault_r <= fault_r | timeout_s;
         case (state_r)
            ST_IDLE:   state_r <= run ? ST_T0 : ST_IDLE;
            ST_T0:     state_r <= ST_T1;
            // Data arrival wins over a timeout in the same cycle
            ST_T1:     state_r <= mem_ready ? ST_T2 : (timeout_s ? ST_HALTED : ST_T1);
            ST_T2:     state_r <= ST_T3;
            ST_T3: begin
               case (op_class_s)
                  OPC_JAL:  state_r <= ST_T4;
                  OPC_BR:   state_r <= ST_T4;
                  OPC_HALT: state_r <= ST_HALTED;
                  default:  state_r <= ST_T0;
               endcase
            end
            ST_T4:     state_r <= (op_class_s == OPC_BR) ? ST_T5 : ST_T0;
            ST_T5:     state_r <= ST_T6;
            ST_T6:     state_r <= ST_T0;
            ST_HALTED: state_r <= run ? ST_T0 : ST_HALTED;
            default:   state_r <= ST_IDLE;
         endcase
      end
   end

   // Strobe decode from state, opcode class, con_ff and mem_ready
   always_comb begin
      PCout      = 1'b0;
      MARin      = 1'b0;
      IncPC      = 1'b0;
      ZLowIn     = 1'b0;
      ZLowOut    = 1'b0;
      PCin       = 1'b0;
      Read       = 1'b0;
      MDRin      = 1'b0;
      MDRout     = 1'b0;
      IRin       = 1'b0;
      Gra        = 1'b0;
      Rout       = 1'b0;
      Rin        = 1'b0;
      CONin      = 1'b0;
      Yin        = 1'b0;
      Cout       = 1'b0;
      alu_add    = 1'b0;
      link_sel   = 1'b0;
      illegal_op = 1'b0;
      case (state_r)
         ST_T0: begin
            PCout  = 1'b1;
            MARin  = 1'b1;
            IncPC  = 1'b1;
            ZLowIn = 1'b1;
         end
         ST_T1: begin
            // Incremented PC is only committed once the fetch completes
            ZLowOut = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
            PCin    = mem_ready;
         end
         ST_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         ST_T3: begin
            case (op_class_s)
               OPC_JR: begin
                  Gra  = 1'b1;
                  Rout = 1'b1;
                  PCin = 1'b1;
               end
               OPC_JAL: begin
                  PCout    = 1'b1;
                  Rin      = 1'b1;
                  link_sel = 1'b1;
               end
               OPC_BR: begin
                  Gra   = 1'b1;
                  Rout  = 1'b1;
                  CONin = 1'b1;
               end
               OPC_HALT: begin
                  illegal_op = 1'b0;
               end
               default: begin
                  illegal_op = 1'b1;
               end
            endcase
         end
         ST_T4: begin
            case (op_class_s)
               OPC_JAL: begin
                  Gra  = 1'b1;
                  Rout = 1'b1;
                  PCin = 1'b1;
               end
               OPC_BR: begin
                  PCout = 1'b1;
                  Yin   = 1'b1;
               end
               default: begin
                  PCout = 1'b0;
               end
            endcase
         end
         ST_T5: begin
            Cout    = 1'b1;
            alu_add = 1'b1;
            ZLowIn  = 1'b1;
         end
         ST_T6: begin
            ZLowOut = 1'b1;
            PCin    = con_ff;
         end
         default: begin
            PCout = 1'b0;
         end
      endcase
   end

   // Register-select lines reserved for future execute sequences
   assign Grb = 1'b0;
   assign Grc = 1'b0;

   assign step   = state_r;
   assign busy   = (state_r != ST_IDLE) && (state_r != ST_HALTED);
   assign halted = (state_r == ST_HALTED);
   assign fault  = fault_r;

endmodule
